gray_decoder: RTL and testbench

Receive-side block for the 3-bit Gray-code counter outputs. It takes a Gray-coded position bus from a slow or asynchronous source, synchronizes it, and decodes it to binary. It classifies each change as a step up, a step down or an illegal jump, and keeps a wrapping position count. It sits between the Gray-count pins or bus and downstream logic on the board clock.

---
 rtl/gray_dec_pkg.sv | 24 ++
 rtl/gray_decoder_sync.sv | 29 ++
 rtl/gray_decoder.sv | 168 ++++++++++++++++
 tb/tb_gray_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_dec_pkg.sv
// Shared types and helpers for the Gray-code position decoder.
package gray_dec_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam int FILL_CYCLES = 2;
  localparam int GRAY_MAX_W  = 32;

  // Callers zero-extend their W-bit code; zero upper bits decode to zero,
  // so the low W bits of the result are the W-bit binary value.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_decoder_sync.sv
// W-bit two-flop synchronizer with asynchronous active-low clear.
module gray_sync
  import gray_dec_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_r;
  logic [W-1:0] s2_r;

  // Two-stage capture of the asynchronous bus.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_r <= {W{1'b0}};
      s2_r <= {W{1'b0}};
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/gray_decoder.sv
// Synchronizes and decodes a Gray position bus, classifies steps, tracks position.
// Optional macro GRAY_DEC_POS_EN builds the position counter; otherwise pos is tied to 0.
module gray_decoder
  import gray_dec_pkg::*;
#(
  parameter int W = 3,
  parameter int P = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] gray_in,
  input  logic         fault_clr,
  output logic [W-1:0] bin,
  output logic         up,
  output logic         dn,
  output logic         err,
  output logic         fault,
  output logic [P-1:0] pos
);

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ONES_W = {W{1'b1}};

  logic [W-1:0] s2_s;
  logic [W-1:0] dec_s;
  logic [W-1:0] delta_s;
  logic         step_up_s;
  logic         step_dn_s;
  logic         step_err_s;
  logic         fill_done_s;

  state_e       state_r;
  state_e       state_nxt_s;
  logic [1:0]   fill_r;
  logic [1:0]   fill_nxt_s;
  logic [W-1:0] bin_r;
  logic [W-1:0] bin_nxt_s;
  logic         up_r;
  logic         dn_r;
  logic         err_r;
  logic         fault_r;
  logic         up_nxt_s;
  logic         dn_nxt_s;
  logic         err_nxt_s;
  logic         fault_nxt_s;

  gray_sync #(.W(W)) u_sync (
    .clk (clk),
    .clr (clr),
    .d   (gray_in),
    .q   (s2_s)
  );

  assign dec_s       = W'(gray2bin(GRAY_MAX_W'(s2_s)));
  assign delta_s     = dec_s - bin_r;
  assign step_up_s   = (delta_s == ONE_W);
  assign step_dn_s   = (delta_s == ONES_W);
  assign step_err_s  = (delta_s != ZERO_W) && !step_up_s && !step_dn_s;
  assign fill_done_s = (fill_r == 2'(FILL_CYCLES));

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= S_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_INIT: begin
        if (fill_done_s) state_nxt_s = S_TRACK;
        else             state_nxt_s = S_INIT;
      end
      S_TRACK: begin
        if (step_err_s) state_nxt_s = S_FAULT;
        else            state_nxt_s = S_TRACK;
      end
      S_FAULT: begin
        if (fault_clr) state_nxt_s = S_INIT;
        else           state_nxt_s = S_FAULT;
      end
      default: state_nxt_s = S_INIT;
    endcase
  end

  // Next values for the registered outputs and the fill counter.
  always_comb begin
    bin_nxt_s  = bin_r;
    fill_nxt_s = fill_r;
    up_nxt_s   = 1'b0;
    dn_nxt_s   = 1'b0;
    err_nxt_s  = 1'b0;
    case (state_r)
      S_INIT: begin
        if (fill_done_s) bin_nxt_s  = dec_s;
        else             fill_nxt_s = fill_r + 2'd1;
      end
      S_TRACK: begin
        bin_nxt_s = dec_s;
        up_nxt_s  = step_up_s;
        dn_nxt_s  = step_dn_s;
        err_nxt_s = step_err_s;
      end
      S_FAULT: begin
        bin_nxt_s = dec_s;
        if (fault_clr) fill_nxt_s = 2'd0;
        else           fill_nxt_s = fill_r;
      end
      default: begin
        bin_nxt_s  = ZERO_W;
        fill_nxt_s = 2'd0;
      end
    endcase
    fault_nxt_s = (state_nxt_s == S_FAULT);
  end

  // Output and fill registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fill_r  <= 2'd0;
      bin_r   <= ZERO_W;
      up_r    <= 1'b0;
      dn_r    <= 1'b0;
      err_r   <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      fill_r  <= fill_nxt_s;
      bin_r   <= bin_nxt_s;
      up_r    <= up_nxt_s;
      dn_r    <= dn_nxt_s;
      err_r   <= err_nxt_s;
      fault_r <= fault_nxt_s;
    end
  end

`ifdef GRAY_DEC_POS_EN
  logic [P-1:0] pos_r;

  // Wrapping position accumulator, stepped by the same decisions as the pulses.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pos_r <= {P{1'b0}};
    end else if (up_nxt_s) begin
      pos_r <= pos_r + {{(P-1){1'b0}}, 1'b1};
    end else if (dn_nxt_s) begin
      pos_r <= pos_r - {{(P-1){1'b0}}, 1'b1};
    end else begin
      pos_r <= pos_r;
    end
  end

  assign pos = pos_r;
`else
  assign pos = {P{1'b0}};
`endif

  assign bin   = bin_r;
  assign up    = up_r;
  assign dn    = dn_r;
  assign err   = err_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder: a cycle model predicts outputs, a monitor compares.
module tb_gray_decoder;

  localparam int W = 3;
  localparam int P = 16;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         clr;
  logic         fault_clr;
  logic [W-1:0] gray_in;
  logic [W-1:0] bin;
  logic         up, dn, err, fault;
  logic [P-1:0] pos;

  typedef struct {
    int bin;
    bit up;
    bit dn;
    bit err;
    bit fault;
    int pos;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   up_seen  = 0;
  int   dn_seen  = 0;
  int   err_seen = 0;

  // Reference model state: mode 0 = priming, 1 = tracking, 2 = faulted.
  int m_mode = 0, m_cnt = 0, m_bin = 0, m_pos = 0, m_p1 = 0, m_p2 = 0;
  bit m_fault = 1'b0;

  gray_decoder #(.W(W), .P(P)) dut (
    .clk       (clk),
    .clr       (clr),
    .gray_in   (gray_in),
    .fault_clr (fault_clr),
    .bin       (bin),
    .up        (up),
    .dn        (dn),
    .err       (err),
    .fault     (fault),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  // Decode by searching for the binary value whose Gray code matches.
  function automatic int g2b(input int g);
    for (int b = 0; b < M; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  task automatic model_edge();
    exp_t e;
    int   d, delta;
    e.up = 1'b0; e.dn = 1'b0; e.err = 1'b0;
    if (!clr) begin
      m_mode = 0; m_cnt = 0; m_bin = 0; m_pos = 0; m_p1 = 0; m_p2 = 0; m_fault = 1'b0;
    end else begin
      d    = g2b(m_p2);
      m_p2 = m_p1;
      m_p1 = int'(gray_in);
      case (m_mode)
        0: begin
          m_cnt++;
          if (m_cnt == 3) begin
            m_bin  = d;
            m_mode = 1;
          end
        end
        1: begin
          delta = (d - m_bin + M) % M;
          if (delta == 1) begin
            e.up = 1'b1; m_bin = d; m_pos = (m_pos + 1) % (1 << P);
          end else if (delta == M - 1) begin
            e.dn = 1'b1; m_bin = d; m_pos = (m_pos + (1 << P) - 1) % (1 << P);
          end else if (delta != 0) begin
            e.err = 1'b1; m_bin = d; m_mode = 2; m_fault = 1'b1;
          end
        end
        default: begin
          m_bin = d;
          if (fault_clr) begin
            m_mode = 0; m_cnt = 0; m_fault = 1'b0;
          end
        end
      endcase
    end
    e.bin   = m_bin;
    e.fault = m_fault;
`ifdef GRAY_DEC_POS_EN
    e.pos = m_pos;
`else
    e.pos = 0;
`endif
    exp_q.push_back(e);
  endtask

  always @(posedge clk) model_edge();

  // Monitor: compare the DUT against the oldest prediction, one per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (int'(bin) == e.bin && up == e.up && dn == e.dn && err == e.err &&
          fault == e.fault && int'(pos) == e.pos) begin
        n_pass++;
      end else begin
        $display("FAIL scoreboard t=%0t: got bin=%0d up=%0b dn=%0b err=%0b fault=%0b pos=%0d, expected bin=%0d up=%0b dn=%0b err=%0b fault=%0b pos=%0d",
                 $time, bin, up, dn, err, fault, pos, e.bin, e.up, e.dn, e.err, e.fault, e.pos);
      end
      if (up)  up_seen++;
      if (dn)  dn_seen++;
      if (err) err_seen++;
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic drive(input int b, input int hold, input logic fc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      gray_in   = W'(b ^ (b >> 1));
      fault_clr = (i == 0) ? fc : 1'b0;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_bin"},   int'(bin),   0);
    check({name, "_pulse"}, int'({up, dn, err}), 0);
    check({name, "_fault"}, int'(fault), 0);
    check({name, "_pos"},   int'(pos),   0);
  endtask

  initial begin
    int u0, d0, e0, cur, r, nb, p0;
    clr = 1'b0; fault_clr = 1'b0; gray_in = 3'b010;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Prime: bin loads the held value on the 3rd edge after release.
    clr = 1'b1;
    u0 = up_seen; d0 = dn_seen;
    repeat (3) @(posedge clk);
    #2;
    check("prime_bin", int'(bin), 3);
    check("prime_pulses", up_seen + dn_seen, u0 + d0);
    check("prime_pos", int'(pos), 0);

    // Walk down to 0, then the full up sequence with wrap.
    drive(2, 4, 1'b0); drive(1, 4, 1'b0); drive(0, 4, 1'b0);
    u0 = up_seen; e0 = err_seen; p0 = int'(pos);
    for (int b = 1; b <= M; b++) drive(b % M, 4, 1'b0);
    check("up_count", up_seen - u0, 8);
    check("up_no_err", err_seen, e0);
    check("up_bin_wrap", int'(bin), 0);
`ifdef GRAY_DEC_POS_EN
    check("up_pos", (int'(pos) - p0 + (1 << P)) % (1 << P), 8);
`else
    check("up_pos_off", int'(pos), 0);
`endif

    // Down steps across the wrap.
    d0 = dn_seen; p0 = int'(pos);
    drive(7, 4, 1'b0); drive(6, 4, 1'b0);
    check("dn_count", dn_seen - d0, 2);
    check("dn_bin", int'(bin), 6);
`ifdef GRAY_DEC_POS_EN
    check("dn_pos", (p0 - int'(pos) + (1 << P)) % (1 << P), 2);
`endif

    // Illegal jump 1 -> 4, fault holds off pulses, clear re-primes silently.
    drive(7, 4, 1'b0); drive(0, 4, 1'b0); drive(1, 4, 1'b0);
    e0 = err_seen; p0 = int'(pos);
    drive(4, 4, 1'b0);
    check("err_count", err_seen - e0, 1);
    check("err_fault", int'(fault), 1);
    check("err_bin", int'(bin), 4);
    check("err_pos", int'(pos), p0);
    u0 = up_seen; d0 = dn_seen;
    drive(5, 4, 1'b0); drive(6, 4, 1'b0);
    check("fault_silent", up_seen + dn_seen, u0 + d0);
    check("fault_bin_follows", int'(bin), 6);
    drive(7, 5, 1'b1);
    check("fault_cleared", int'(fault), 0);
    check("reprime_silent", up_seen + dn_seen, u0 + d0);
    check("reprime_bin", int'(bin), 7);

    // Randomized walk: mostly legal steps, some jumps, holds and clears.
    cur = 7;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      nb = (cur + 1) % M;
      else if (r <= 6) nb = (cur + M - 1) % M;
      else if (r == 7) nb = $urandom_range(0, M - 1);
      else             nb = cur;
      drive(nb, $urandom_range(1, 3), (r == 9) ? 1'b1 : 1'b0);
      cur = nb;
    end
    drive(cur, 4, 1'b1);

    // Asynchronous reset while a step is still in the synchronizer.
    drive(cur, 3, 1'b0);
    cur = (cur + 1) % M;
    drive(cur, 1, 1'b0);
    @(posedge clk);
    #2 clr = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    clr = 1'b1;
    u0 = up_seen; d0 = dn_seen; e0 = err_seen;
    repeat (3) @(posedge clk);
    #2;
    check("midreset_prime_bin", int'(bin), cur);
    check("midreset_no_stale", up_seen + dn_seen + err_seen, u0 + d0 + e0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
